// File: rtl/sram_2_16_1_freepdk45_pkg.sv
// Shared geometry and operation decode for the 2-bit x 16-word single-port SRAM.
package sram_2_16_1_pkg;

  localparam int WORD_SIZE  = 2;
  localparam int ADDR_WIDTH = 4;
  localparam int NUM_WORDS  = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } op_e;

  // Chip select dominates; with the chip selected, WEb picks write (low) or read (high).
  function automatic op_e decode_op(input logic csb, input logic web);
    if (csb) return IDLE;
    return web ? READ : WRITE;
  endfunction

endpackage

// File: rtl/sram_2_16_1_freepdk45_if.sv
// Control bus of the SRAM: address, chip select, write enable and output enable.
interface sram_2_16_1_freepdk45_if
  import sram_2_16_1_pkg::*;
#(
  parameter int ADDR_WIDTH = sram_2_16_1_pkg::ADDR_WIDTH
);

  logic [ADDR_WIDTH-1:0] ADDR;
  logic                  CSb;
  logic                  WEb;
  logic                  OEb;

  modport master (output ADDR, CSb, WEb, OEb);
  modport slave  (input  ADDR, CSb, WEb, OEb);

endinterface

// File: rtl/sram_2_16_1_freepdk45_array.sv
// Storage array: synchronous write port, registered read port, asynchronous clear.
module sram_2_16_1_array
  import sram_2_16_1_pkg::*;
#(
  parameter int WORD_SIZE  = sram_2_16_1_pkg::WORD_SIZE,
  parameter int ADDR_WIDTH = sram_2_16_1_pkg::ADDR_WIDTH,
  parameter int NUM_WORDS  = sram_2_16_1_pkg::NUM_WORDS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WORD_SIZE-1:0]  wdata,
  output logic [WORD_SIZE-1:0]  rdata
);

  logic [WORD_SIZE-1:0] mem [NUM_WORDS];

  // NOTE: the array is reset on purpose because reset must return every word as 0;
  // this forces flip-flop storage, so a plain RAM macro cannot be inferred here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_WORDS; i++) mem[i] <= '0;
      rdata <= '0;
    end else begin
      if (we) mem[addr] <= wdata;
      if (re) rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/sram_2_16_1_freepdk45.sv
// Single-port 2x16 SRAM top: control registers, storage array and tri-state data driver.
module sram_2_16_1_freepdk45
  import sram_2_16_1_pkg::*;
#(
  parameter int WORD_SIZE  = sram_2_16_1_pkg::WORD_SIZE,
  parameter int ADDR_WIDTH = sram_2_16_1_pkg::ADDR_WIDTH,
  parameter int NUM_WORDS  = sram_2_16_1_pkg::NUM_WORDS
) (
  input  logic                 clk,
  input  logic                 RSTb,
  inout  wire  [WORD_SIZE-1:0] DATA,
  sram_2_16_1_freepdk45_if.slave bus
);

  op_e                  op;
  logic                 csb_q;
  logic                 web_q;
  logic                 read_valid;
  logic                 drive_en;
  logic [WORD_SIZE-1:0] dout;

  assign op = decode_op(bus.CSb, bus.WEb);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge RSTb) begin
    if (!RSTb) begin
      csb_q <= 1'b1;
      web_q <= 1'b1;
    end else begin
      csb_q <= bus.CSb;
      web_q <= bus.WEb;
    end
  end

  // A selected read at the last edge is the only state that leaves dout valid.
  assign read_valid = !csb_q && web_q;

  // OEb and WEb gate the driver combinationally so a write never fights the bus.
  assign drive_en = !bus.OEb && read_valid && bus.WEb;
  assign DATA     = drive_en ? dout : {WORD_SIZE{1'bz}};

  sram_2_16_1_array #(
    .WORD_SIZE  (WORD_SIZE),
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_WORDS  (NUM_WORDS)
  ) u_array (
    .clk   (clk),
    .rst_n (RSTb),
    .we    (op == WRITE),
    .re    (op == READ),
    .addr  (bus.ADDR),
    .wdata (DATA),
    .rdata (dout)
  );

endmodule

// File: tb/tb_sram_2_16_1_freepdk45.sv
// Directed bench for the 2x16 SRAM; a released bus is pulled high so high-Z reads as 2'b11.
module tb_sram_2_16_1_freepdk45;

  localparam logic [1:0] RELEASED = 2'b11;

  logic       clk = 1'b0;
  logic       rstb;
  logic       tb_drive;
  logic [1:0] tb_data;
  wire  [1:0] data_bus;

  int checks   = 0;
  int failures = 0;

  sram_2_16_1_freepdk45_if #(.ADDR_WIDTH(4)) bus_if ();

  pullup pu0 (data_bus[0]);
  pullup pu1 (data_bus[1]);

  assign data_bus = tb_drive ? tb_data : 2'bzz;

  sram_2_16_1_freepdk45 dut (
    .clk  (clk),
    .RSTb (rstb),
    .DATA (data_bus),
    .bus  (bus_if.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [1:0] observed, input logic [1:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s: observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  // Advance past the next rising edge and settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ctrl(input logic csb, input logic web, input logic oeb, input logic [3:0] addr);
    bus_if.CSb  = csb;
    bus_if.WEb  = web;
    bus_if.OEb  = oeb;
    bus_if.ADDR = addr;
  endtask

  initial begin
    // Reset held across edges with a read requested: edges must be ignored.
    rstb     = 1'b0;
    tb_drive = 1'b0;
    tb_data  = 2'b00;
    set_ctrl(1'b0, 1'b1, 1'b0, 4'h0);
    #1;
    check("reset_hiz_initial", data_bus, RELEASED);
    step();
    step();
    check("reset_hiz_edges", data_bus, RELEASED);

    rstb = 1'b1;
    step();
    check("read_addr0_after_reset", data_bus, 2'b00);

    // Writes with the bench driving; device must stay off the bus afterwards.
    set_ctrl(1'b0, 1'b0, 1'b1, 4'h1);
    tb_data  = 2'b10;
    tb_drive = 1'b1;
    step();
    tb_drive = 1'b0;
    #1;
    check("write_addr1_hiz", data_bus, RELEASED);

    set_ctrl(1'b0, 1'b0, 1'b0, 4'hC);
    tb_data  = 2'b01;
    tb_drive = 1'b1;
    step();
    tb_drive = 1'b0;
    #1;
    check("write_addrC_hiz_oe_low", data_bus, RELEASED);

    // Reads back in reverse order.
    set_ctrl(1'b0, 1'b1, 1'b0, 4'hC);
    step();
    check("read_addrC", data_bus, 2'b01);
    set_ctrl(1'b0, 1'b1, 1'b0, 4'h1);
    step();
    check("read_addr1", data_bus, 2'b10);

    // OEb gates the driver with no clock edge involved.
    #1 bus_if.OEb = 1'b1;
    #1 check("oe_high_hiz", data_bus, RELEASED);
    bus_if.OEb = 1'b0;
    #1 check("oe_low_redrive", data_bus, 2'b10);

    // WEb low must release the bus even with OEb low and valid data.
    bus_if.WEb = 1'b0;
    #1 check("we_low_hiz", data_bus, RELEASED);
    bus_if.WEb = 1'b1;
    #1 check("we_high_redrive", data_bus, 2'b10);

    // Deselected write attempt must not touch memory.
    set_ctrl(1'b1, 1'b0, 1'b0, 4'h1);
    tb_data  = 2'b11;
    tb_drive = 1'b1;
    step();
    tb_drive = 1'b0;
    #1;
    check("deselect_hiz", data_bus, RELEASED);
    bus_if.WEb = 1'b1;
    #1 check("deselect_hiz_we_high", data_bus, RELEASED);
    set_ctrl(1'b0, 1'b1, 1'b0, 4'h1);
    step();
    check("read_addr1_unchanged", data_bus, 2'b10);

    // Read-after-write at the very next edge.
    set_ctrl(1'b0, 1'b0, 1'b1, 4'hF);
    tb_data  = 2'b11;
    tb_drive = 1'b1;
    step();
    tb_drive = 1'b0;
    set_ctrl(1'b0, 1'b1, 1'b0, 4'hF);
    step();
    check("read_addrF_written", data_bus, 2'b11);

    // Rewrite F, then reset mid-cycle: the word and dout must come back as 0.
    set_ctrl(1'b0, 1'b0, 1'b1, 4'hF);
    tb_drive = 1'b1;
    step();
    tb_drive = 1'b0;
    set_ctrl(1'b0, 1'b1, 1'b0, 4'hF);
    #2 rstb = 1'b0;
    #1 check("reset_mid_cycle_hiz", data_bus, RELEASED);
    step();
    check("reset_edge_ignored_hiz", data_bus, RELEASED);
    rstb = 1'b1;
    #1 check("reset_release_no_edge_hiz", data_bus, RELEASED);
    step();
    check("read_addrF_cleared", data_bus, 2'b00);
    set_ctrl(1'b0, 1'b1, 1'b0, 4'h1);
    step();
    check("read_addr1_cleared", data_bus, 2'b00);
    set_ctrl(1'b0, 1'b1, 1'b0, 4'hC);
    step();
    check("read_addrC_cleared", data_bus, 2'b00);

    set_ctrl(1'b1, 1'b1, 1'b1, 4'h0);
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
